// File: rtl/trigger_pkg.sv
// trigger_pkg: shared state type, pulse-width limits and latency helper for the trigger sequencer.
package trigger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SER_HI,
        SER_GAP,
        VS_HI,
        VS_GAP,
        BP_HI,
        BP_LO,
        DONE
    } state_t;

    // The downstream counter re-samples 3 cycles after a hit, so pulses must stay within this window.
    localparam int PW_MIN = 1;
    localparam int PW_MAX = 3;

    function automatic int first_plane_latency(input int pw, input int s2v, input int v2p);
        return 1 + 2 * pw + s2v + v2p;
    endfunction

endpackage

// File: rtl/bitplane_trigger_gen_if.sv
// bitplane_trigger_gen_if: start request plus trigger/status outputs of the trigger sequencer.
interface bitplane_trigger_gen_if;

    logic       start;
    logic       serial;
    logic       vsync;
    logic       bitplane;
    logic       busy;
    logic       frame_done;
    logic [7:0] plane_idx;

    modport master (
        output start,
        input  serial, vsync, bitplane, busy, frame_done, plane_idx
    );

    modport slave (
        input  start,
        output serial, vsync, bitplane, busy, frame_done, plane_idx
    );

endinterface

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter that parks at zero and flags it.
module pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_zero = r_cnt == '0;

endmodule

// File: rtl/bitplane_trigger_gen.sv
// bitplane_trigger_gen: emits serial, vsync and N bitplane pulses per frame request.
// Define BITPLANE_TRIGGER_GEN_REPEAT_EN to chain frames from DONE straight into SER_GAP.
module bitplane_trigger_gen
    import trigger_pkg::*;
#(
    parameter int N_BIT_PLANES    = 12,
    parameter int PULSE_WIDTH     = 2,
    parameter int SERIAL_TO_VSYNC = 16,
    parameter int VSYNC_TO_PLANE  = 64,
    parameter int PLANE_PERIOD    = 1000,
    parameter int CNT_W           = 16
) (
    input logic                   clk,
    input logic                   rst,
    bitplane_trigger_gen_if.slave bus
);

    localparam longint MAX_DUR = longint'(1) << CNT_W;

    if (N_BIT_PLANES < 1 || N_BIT_PLANES > 255) begin : g_bad_planes
        $error("N_BIT_PLANES must be 1..255");
    end
    if (PULSE_WIDTH < PW_MIN || PULSE_WIDTH > PW_MAX) begin : g_bad_pw
        $error("PULSE_WIDTH must be 1..3");
    end
    if (SERIAL_TO_VSYNC < 1 || VSYNC_TO_PLANE < 1) begin : g_bad_gap
        $error("SERIAL_TO_VSYNC and VSYNC_TO_PLANE must be at least 1");
    end
    if (PLANE_PERIOD < PULSE_WIDTH + 4) begin : g_bad_period
        $error("PLANE_PERIOD must be at least PULSE_WIDTH+4");
    end
    if (longint'(SERIAL_TO_VSYNC) >= MAX_DUR || longint'(VSYNC_TO_PLANE) >= MAX_DUR ||
        longint'(PLANE_PERIOD) >= MAX_DUR) begin : g_bad_width
        $error("durations must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] L_PW      = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] L_SER_GAP = CNT_W'(SERIAL_TO_VSYNC - 1);
    localparam logic [CNT_W-1:0] L_VS_GAP  = CNT_W'(VSYNC_TO_PLANE - 1);
    localparam logic [CNT_W-1:0] L_BP_LO   = CNT_W'(PLANE_PERIOD - PULSE_WIDTH - 1);
    localparam logic [7:0]       L_LAST    = 8'(N_BIT_PLANES - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_zero;
    logic             w_load;
    logic             w_last;
    logic [CNT_W-1:0] w_value;
    logic             r_serial;
    logic             r_vsync;
    logic             r_bitplane;
    logic             r_busy;
    logic             r_frame_done;
    logic [7:0]       r_plane_idx;

    assign w_last = r_plane_idx == L_LAST;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = bus.start ? SER_HI : IDLE;
            SER_HI:  w_next = w_zero ? SER_GAP : SER_HI;
            SER_GAP: w_next = w_zero ? VS_HI : SER_GAP;
            VS_HI:   w_next = w_zero ? VS_GAP : VS_HI;
            VS_GAP:  w_next = w_zero ? BP_HI : VS_GAP;
            BP_HI:   w_next = w_zero ? BP_LO : BP_HI;
            BP_LO:   w_next = w_zero ? (w_last ? DONE : BP_HI) : BP_LO;
`ifdef BITPLANE_TRIGGER_GEN_REPEAT_EN
            DONE:    w_next = bus.start ? SER_GAP : IDLE;
`else
            DONE:    w_next = IDLE;
`endif
        endcase
    end

    // Every advance changes state, so a state change is exactly a timer reload.
    assign w_load  = w_next != r_state;
    assign w_value = (w_next == SER_GAP) ? L_SER_GAP :
                     (w_next == VS_GAP)  ? L_VS_GAP  :
                     (w_next == BP_LO)   ? L_BP_LO   :
                     (w_next == SER_HI || w_next == VS_HI || w_next == BP_HI) ? L_PW : '0;

    pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_value(w_value),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Outputs decode the next state so each one is a flop aligned with its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_serial     <= 1'b0;
            r_vsync      <= 1'b0;
            r_bitplane   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_plane_idx  <= '0;
        end else begin
            r_serial     <= w_next == SER_HI;
            r_vsync      <= w_next == VS_HI;
            r_bitplane   <= w_next == BP_HI;
            r_busy       <= w_next != IDLE;
            r_frame_done <= w_next == DONE;
            if (r_state == VS_GAP && w_zero)
                r_plane_idx <= '0;
            else if (r_state == BP_LO && w_zero && !w_last)
                r_plane_idx <= r_plane_idx + 8'd1;
        end
    end

    assign bus.serial     = r_serial;
    assign bus.vsync      = r_vsync;
    assign bus.bitplane   = r_bitplane;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.plane_idx  = r_plane_idx;

endmodule
